// File: rtl/peak_track.sv
// -----------------------------------------------------------------------------
// peak_track
//
// Sits behind the FFT peak detector. Collects one NPEAKS-entry peak frame
// (freq, mag, phaseA, phaseB), resolves the two-way phase ambiguity of each
// peak against that peak's phase in the previous frame, keeps a per-peak
// frequency-stability lock counter, and re-emits the frame over a
// valid/ready stream. All data is 32-bit two's complement with 8 fractional
// bits.
//
// Optional build macro: PEAK_TRACK_UNWRAP_EN
//   defined   : source_phase is an unwrapped cumulative phase
//               (previous phase + chosen wrapped delta, modulo 2^32).
//   undefined : source_phase is the chosen raw candidate.
//
// Ports
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   hist_clr          clear all per-peak history (deferred while busy)
//   sink_*            input frame stream, no backpressure
//   source_ready      consumer accepts the current output entry
//   source_*          registered output entry (idx, freq, mag, phase, lock)
//   frame_err         one-cycle pulse on a malformed frame
//   overrun           one-cycle pulse when a frame starts while busy
// -----------------------------------------------------------------------------
module peak_track #(
    parameter int NPEAKS   = 4,
    parameter int FREQ_TOL = 2560,
    parameter int LOCK_CNT = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      hist_clr,
    input  logic                      sink_sop,
    input  logic                      sink_eop,
    input  logic                      sink_valid,
    input  logic [31:0]               sink_freq,
    input  logic [31:0]               sink_mag,
    input  logic [31:0]               sink_phaseA,
    input  logic [31:0]               sink_phaseB,
    input  logic                      source_ready,
    output logic                      source_valid,
    output logic                      source_sop,
    output logic                      source_eop,
    output logic [$clog2(NPEAKS)-1:0] source_idx,
    output logic [31:0]               source_freq,
    output logic [31:0]               source_mag,
    output logic [31:0]               source_phase,
    output logic                      source_lock,
    output logic                      frame_err,
    output logic                      overrun
);

    localparam int                IW        = $clog2(NPEAKS);
    localparam int                LW        = $clog2(LOCK_CNT + 1);
    localparam logic [IW-1:0]     LAST      = IW'(NPEAKS - 1);
    localparam logic [LW-1:0]     LOCK_MAX  = LW'(LOCK_CNT);
    localparam logic signed [32:0] HALF_TURN = 33'sd46080;   // 180 deg
    localparam logic signed [32:0] FULL_TURN = 33'sd92160;   // 360 deg

    typedef enum logic [1:0] {IDLE, COLLECT, RESOLVE, EMIT} state_t;

    state_t state, state_nxt;

    // idx is the collect count, the resolve pointer and the emit pointer.
    logic [IW-1:0]     idx;
    logic [31:0]       freq_buf   [NPEAKS];
    logic [31:0]       mag_buf    [NPEAKS];
    logic [31:0]       pha_buf    [NPEAKS];
    logic [31:0]       phb_buf    [NPEAKS];
    logic [31:0]       res_buf    [NPEAKS];
    logic [31:0]       hist_phase [NPEAKS];
    logic [31:0]       hist_freq  [NPEAKS];
    logic [LW-1:0]     lock_cnt   [NPEAKS];
    logic [NPEAKS-1:0] hist_valid;
    logic              clr_pend;

    function automatic logic signed [32:0] sx(input logic [31:0] v);
        return $signed({v[31], v});
    endfunction

    // Bring a phase difference into (-180, 180] degrees with one correction.
    function automatic logic signed [32:0] wrap(input logic signed [32:0] d);
        if (d > HALF_TURN)   return d - FULL_TURN;
        if (d <= -HALF_TURN) return d + FULL_TURN;
        return d;
    endfunction

    function automatic logic [32:0] abs33(input logic signed [32:0] d);
        return d[32] ? $unsigned(-d) : $unsigned(d);
    endfunction

    // ---------------------------------------------------------------- control
    logic          store_en, err_nxt, ovr_nxt, emit_load, emit_done, hist_wipe;
    logic [IW-1:0] store_ptr, emit_sel;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave a latch behind.
    always_comb begin
        state_nxt = state;
        store_en  = 1'b0;
        store_ptr = idx;
        err_nxt   = 1'b0;
        ovr_nxt   = 1'b0;
        emit_load = 1'b0;
        emit_done = 1'b0;
        emit_sel  = idx;
        case (state)
            IDLE: begin
                if (sink_valid && sink_sop) begin
                    store_en  = 1'b1;
                    store_ptr = '0;
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (sink_valid) begin
                    if (sink_sop) begin
                        store_en  = 1'b1;
                        store_ptr = '0;
                        err_nxt   = 1'b1;
                    end else if (sink_eop && idx == LAST) begin
                        store_en  = 1'b1;
                        state_nxt = RESOLVE;
                    end else if (sink_eop || idx == LAST) begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        store_en  = 1'b1;
                    end
                end
            end
            RESOLVE: begin
                ovr_nxt = sink_valid && sink_sop;
                if (idx == LAST) state_nxt = EMIT;
            end
            EMIT: begin
                ovr_nxt = sink_valid && sink_sop;
                if (!source_valid) begin
                    emit_load = 1'b1;
                end else if (source_ready) begin
                    if (idx == LAST) begin
                        emit_done = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        emit_load = 1'b1;
                        emit_sel  = idx + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A clear seen while busy is held until the frame has been emitted.
    assign hist_wipe = (hist_clr && (state == IDLE || state == COLLECT)) ||
                       (emit_done && (hist_clr || clr_pend));

    // ---------------------------------------------------------------- resolve
    logic signed [32:0] d_a, d_b, d_f;
    logic               take_b;
    logic [31:0]        phase_res;
    logic [LW-1:0]      lock_nxt;

    always_comb begin
        d_a    = wrap(sx(pha_buf[idx]) - sx(hist_phase[idx]));
        d_b    = wrap(sx(phb_buf[idx]) - sx(hist_phase[idx]));
        d_f    = sx(freq_buf[idx]) - sx(hist_freq[idx]);
        // Strictly closer B wins; a tie or a peak without history keeps A.
        take_b = hist_valid[idx] && (abs33(d_b) < abs33(d_a));
`ifdef PEAK_TRACK_UNWRAP_EN
        if (!hist_valid[idx])
            phase_res = pha_buf[idx];
        else
            phase_res = hist_phase[idx] + 32'(take_b ? d_b : d_a);
`else
        phase_res = take_b ? phb_buf[idx] : pha_buf[idx];
`endif
        if (hist_valid[idx] && abs33(d_f) <= 33'(FREQ_TOL))
            lock_nxt = (lock_cnt[idx] == LOCK_MAX) ? LOCK_MAX : lock_cnt[idx] + 1'b1;
        else
            lock_nxt = '0;
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here samples the values that existed before the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx          <= '0;
            hist_valid   <= '0;
            clr_pend     <= 1'b0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
            source_valid <= 1'b0;
            source_sop   <= 1'b0;
            source_eop   <= 1'b0;
            source_idx   <= '0;
            source_freq  <= '0;
            source_mag   <= '0;
            source_phase <= '0;
            source_lock  <= 1'b0;
            // NOTE: the arrays are reset as well, not just their valid bits,
            // so nothing stale from before reset can ever reach an output.
            for (int i = 0; i < NPEAKS; i++) begin
                freq_buf[i]   <= '0;
                mag_buf[i]    <= '0;
                pha_buf[i]    <= '0;
                phb_buf[i]    <= '0;
                res_buf[i]    <= '0;
                hist_phase[i] <= '0;
                hist_freq[i]  <= '0;
                lock_cnt[i]   <= '0;
            end
        end else begin
            frame_err <= err_nxt;
            overrun   <= ovr_nxt;

            // Storing the last entry wraps idx to 0, ready for RESOLVE.
            if (store_en) begin
                freq_buf[store_ptr] <= sink_freq;
                mag_buf[store_ptr]  <= sink_mag;
                pha_buf[store_ptr]  <= sink_phaseA;
                phb_buf[store_ptr]  <= sink_phaseB;
                idx                 <= store_ptr + 1'b1;
            end

            // The last resolve step also wraps idx to 0, ready for EMIT.
            if (state == RESOLVE) begin
                res_buf[idx]    <= phase_res;
                lock_cnt[idx]   <= lock_nxt;
                hist_phase[idx] <= phase_res;
                hist_freq[idx]  <= freq_buf[idx];
                hist_valid[idx] <= 1'b1;
                idx             <= idx + 1'b1;
            end

            if (emit_load) begin
                source_valid <= 1'b1;
                source_sop   <= (emit_sel == '0);
                source_eop   <= (emit_sel == LAST);
                source_idx   <= emit_sel;
                source_freq  <= freq_buf[emit_sel];
                source_mag   <= mag_buf[emit_sel];
                source_phase <= res_buf[emit_sel];
                source_lock  <= (lock_cnt[emit_sel] == LOCK_MAX);
                idx          <= emit_sel;
            end
            if (emit_done) source_valid <= 1'b0;

            if (hist_clr && (state == RESOLVE || state == EMIT)) clr_pend <= 1'b1;
            if (hist_wipe) begin
                hist_valid <= '0;
                clr_pend   <= 1'b0;
                for (int i = 0; i < NPEAKS; i++) begin
                    hist_phase[i] <= '0;
                    hist_freq[i]  <= '0;
                    lock_cnt[i]   <= '0;
                end
            end
        end
    end

endmodule
